// File: rtl/div_pkg.sv
// div_pkg: shared state codes for the iterative divider
package div_pkg;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/div_if.sv
// div_if: request/result bundle between the control unit and the divider
interface div_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring division iteration on the {rem,quo} pair
module div_step #(parameter int WIDTH = 8) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        // a negative trial means the shifted remainder was below the divisor, so it fits WIDTH bits
        next_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        next_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative unsigned restoring divider, one quotient bit per clock
module div_unit
    import div_pkg::*;
#(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    div_state_t       state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n;
    logic             accept, zero_div;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .next_rem (rem_n),
        .next_quo (quo_n)
    );
    always_comb begin
        accept   = (state != DIV_RUN) && bus.start;
        zero_div = bus.divisor == '0;
        state_n  = accept ? (zero_div ? DIV_DONE : DIV_RUN)
                 : state == DIV_RUN ? (cnt == CW'(1) ? DIV_DONE : DIV_RUN)
                 : DIV_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= DIV_IDLE;
            cnt             <= '0;
            rem             <= '0;
            quo             <= '0;
            dvs             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            state    <= state_n;
            bus.busy <= state_n == DIV_RUN;
            bus.done <= state_n == DIV_DONE;
            if (accept) begin
                dvs             <= bus.divisor;
                rem             <= '0;
                quo             <= bus.dividend;
                cnt             <= CW'(WIDTH);
                bus.div_by_zero <= zero_div;
                if (zero_div) begin
                    bus.quotient  <= '1;
                    bus.remainder <= bus.dividend;
                end
            end else if (state == DIV_RUN) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    bus.quotient  <= quo_n;
                    bus.remainder <= rem_n;
                end
            end
        end
    end
endmodule
